// File: rtl/fb_slave_rx_fsm_p.sv
// rtl/fb_slave_rx_fsm_p.sv - FREEDM slave receive frame FSM tracking preamble, SoC and all frame fields
module fb_slave_rx_fsm_p #(
    parameter int SLOT_NIB    = 8,
    parameter int CRC_NIB     = 4,
    parameter int FRM_CRC_NIB = 8,
    parameter int ID_NIB      = 2,
    parameter int DIST_NIB    = 4,
    parameter int DELAY_NIB   = 2,
    parameter int MAX_SLAVES  = 16,
    parameter int SLV_W       = 4
) (
    input  logic             MRxClk,
    input  logic             Reset_n,
    input  logic             MRxDV,
    input  logic [3:0]       MRxD,
    input  logic [SLV_W-1:0] MySlaveId,
    input  logic [SLV_W:0]   NumSlaves,
    output logic [3:0]       State,
    output logic [2:0]       FrameType,
    output logic [SLV_W-1:0] SlotIdx,
    output logic [3:0]       NibCnt,
    output logic             OwnSlot,
    output logic             FrameDone,
    output logic             FrameErr
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FFS     = 4'd1,
        PRE     = 4'd2,
        SLOT    = 4'd3,
        SCRC    = 4'd4,
        NUMB    = 4'd5,
        DIST    = 4'd6,
        DELAY   = 4'd7,
        DLYDIST = 4'd8,
        FRMCRC  = 4'd9
    } state_t;

    localparam logic [SLV_W:0] MaxSlaves = (SLV_W+1)'(MAX_SLAVES);
    localparam logic [3:0] SlotLast  = 4'(SLOT_NIB - 1);
    localparam logic [3:0] CrcLast   = 4'(CRC_NIB - 1);
    localparam logic [3:0] FrmLast   = 4'(FRM_CRC_NIB - 1);
    localparam logic [3:0] IdLast    = 4'(ID_NIB - 1);
    localparam logic [3:0] DistLast  = 4'(DIST_NIB - 1);
    localparam logic [3:0] DelayLast = 4'(DELAY_NIB - 1);

    state_t           curState, nextState;
    logic [2:0]       frameTypeN;
    logic [SLV_W-1:0] slotIdxN;
    logic [3:0]       nibCntN, lastNib;
    logic [SLV_W:0]   slotCount, slotCountN, satNum;
    logic             frameDoneN, frameErrN, fieldEnd, lastSlot;

    assign satNum   = (NumSlaves > MaxSlaves) ? MaxSlaves : NumSlaves;
    assign fieldEnd = (NibCnt == lastNib);
    assign lastSlot = (({1'b0, SlotIdx} + (SLV_W+1)'(1)) == slotCount);

    always_comb begin
        lastNib = 4'd0;
        case (curState)
            SLOT:    lastNib = SlotLast;
            SCRC:    lastNib = CrcLast;
            NUMB:    lastNib = IdLast;
            DIST:    lastNib = DistLast;
            DELAY:   lastNib = DelayLast;
            DLYDIST: lastNib = DistLast;
            FRMCRC:  lastNib = FrmLast;
            default: lastNib = 4'd0;
        endcase
    end

    always_comb begin
        nextState  = curState;
        frameTypeN = FrameType;
        slotIdxN   = SlotIdx;
        nibCntN    = NibCnt;
        slotCountN = slotCount;
        frameDoneN = 1'b0;
        frameErrN  = 1'b0;
        case (curState)
            IDLE: begin
                slotIdxN = '0;
                nibCntN  = '0;
                if (MRxDV) nextState = (MRxD == 4'h5) ? PRE : FFS;
            end
            FFS: begin
                nibCntN = '0;
                if (!MRxDV) nextState = IDLE;
                else if (MRxD == 4'h5) nextState = PRE;
            end
            PRE: begin
                nibCntN = '0;
                if (!MRxDV) begin
                    nextState = IDLE;
                end else begin
                    case (MRxD)
                        4'h5: nextState = PRE;
                        4'hD: begin
                            frameTypeN = 3'd1;
                            slotIdxN   = '0;
                            slotCountN = satNum;
                            nextState  = (satNum == '0) ? FRMCRC : SLOT;
                        end
                        4'h9: begin frameTypeN = 3'd2; nextState = NUMB;    end
                        4'hA: begin frameTypeN = 3'd3; nextState = DIST;    end
                        4'hB: begin frameTypeN = 3'd4; nextState = DELAY;   end
                        4'hC: begin frameTypeN = 3'd5; nextState = DLYDIST; end
                        default: begin
                            nextState = FFS;
                            frameErrN = 1'b1;
                        end
                    endcase
                end
            end
            SLOT, SCRC, NUMB, DIST, DELAY, DLYDIST, FRMCRC: begin
                if (!MRxDV) begin
                    // Premature loss of carrier inside a field discards the frame
                    nextState  = IDLE;
                    frameErrN  = 1'b1;
                    frameTypeN = 3'd0;
                    slotIdxN   = '0;
                    nibCntN    = '0;
                end else if (!fieldEnd) begin
                    nibCntN = NibCnt + 4'd1;
                end else begin
                    nibCntN = '0;
                    case (curState)
                        SLOT: nextState = SCRC;
                        SCRC: begin
                            if (lastSlot) begin
                                nextState = FRMCRC;
                            end else begin
                                slotIdxN  = SlotIdx + SLV_W'(1);
                                nextState = SLOT;
                            end
                        end
                        FRMCRC: begin
                            nextState  = IDLE;
                            frameDoneN = 1'b1;
                            slotIdxN   = '0;
                        end
                        default: nextState = FRMCRC;
                    endcase
                end
            end
            default: begin
                nextState = IDLE;
                slotIdxN  = '0;
                nibCntN   = '0;
            end
        endcase
    end

    always_ff @(posedge MRxClk or negedge Reset_n) begin
        if (!Reset_n) begin
            curState  <= IDLE;
            FrameType <= 3'd0;
            SlotIdx   <= '0;
            NibCnt    <= 4'd0;
            slotCount <= '0;
            FrameDone <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            curState  <= nextState;
            FrameType <= frameTypeN;
            SlotIdx   <= slotIdxN;
            NibCnt    <= nibCntN;
            slotCount <= slotCountN;
            FrameDone <= frameDoneN;
            FrameErr  <= frameErrN;
        end
    end

    assign State   = curState;
    assign OwnSlot = (curState == SLOT) && (SlotIdx == MySlaveId) && MRxDV;

endmodule

// File: tb/tb_fb_slave_rx_fsm_p.sv
// tb/tb_fb_slave_rx_fsm_p.sv - randomized frame-level bench for fb_slave_rx_fsm_p
module tb_fb_slave_rx_fsm_p;

    localparam int SLOT_NIB = 8, CRC_NIB = 4, FRM_CRC_NIB = 8, ID_NIB = 2;
    localparam int DIST_NIB = 4, DELAY_NIB = 2, MAX_SLAVES = 16;
    localparam logic [3:0] S_IDLE = 4'd0, S_FFS = 4'd1, S_PRE = 4'd2, S_SLOT = 4'd3, S_SCRC = 4'd4;
    localparam logic [3:0] S_NUMB = 4'd5, S_DIST = 4'd6, S_DELAY = 4'd7, S_DLYDIST = 4'd8, S_FRMCRC = 4'd9;

    logic       MRxClk = 1'b0, Reset_n = 1'b0, MRxDV = 1'b0;
    logic [3:0] MRxD = 4'h0, MySlaveId = 4'h0;
    logic [4:0] NumSlaves = 5'd0;
    logic [3:0] State, NibCnt, SlotIdx;
    logic [2:0] FrameType;
    logic       OwnSlot, FrameDone, FrameErr;

    int checks = 0, errors = 0, ownCnt = 0, expOwn = 0;
    logic [2:0] mType = 3'd0;

    typedef struct packed {
        logic dv; logic [3:0] d; logic [3:0] st; logic [2:0] ty;
        logic [3:0] sl; logic [3:0] nc; logic dn; logic er;
    } step_t;
    step_t q[$];

    fb_slave_rx_fsm_p dut (
        .MRxClk(MRxClk), .Reset_n(Reset_n), .MRxDV(MRxDV), .MRxD(MRxD),
        .MySlaveId(MySlaveId), .NumSlaves(NumSlaves), .State(State),
        .FrameType(FrameType), .SlotIdx(SlotIdx), .NibCnt(NibCnt),
        .OwnSlot(OwnSlot), .FrameDone(FrameDone), .FrameErr(FrameErr)
    );

    always #5 MRxClk = ~MRxClk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic dv, input logic [3:0] d, input logic [3:0] st, input logic [2:0] ty,
                        input logic [3:0] sl, input logic [3:0] nc, input logic dn, input logic er);
        step_t s;
        s = '{dv: dv, d: d, st: st, ty: ty, sl: sl, nc: nc, dn: dn, er: er};
        q.push_back(s);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 4'h0, S_IDLE, mType, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // Frame model: a frame is a list of fields (state, slot, length); the expected
    // outputs after each nibble follow from where that nibble sits in the list.
    task automatic build(input int garbage, input int preLen, input logic [3:0] soc,
                         input int ns, input int my, input int abortAt);
        logic [3:0] fS[$];
        int fSl[$];
        int fL[$];
        int eff, n;
        logic [3:0] g;
        eff = 0;
        for (int i = 0; i < garbage; i++) begin
            g = 4'($urandom_range(0, 15));
            if (g == 4'h5) g = 4'h6;
            push(1'b1, g, S_FFS, mType, 4'd0, 4'd0, 1'b0, 1'b0);
        end
        for (int i = 0; i < preLen; i++) push(1'b1, 4'h5, S_PRE, mType, 4'd0, 4'd0, 1'b0, 1'b0);
        case (soc)
            4'hD: begin
                mType = 3'd1;
                eff = (ns > MAX_SLAVES) ? MAX_SLAVES : ns;
                for (int s = 0; s < eff; s++) begin
                    fS.push_back(S_SLOT); fSl.push_back(s); fL.push_back(SLOT_NIB);
                    fS.push_back(S_SCRC); fSl.push_back(s); fL.push_back(CRC_NIB);
                end
            end
            4'h9: begin mType = 3'd2; fS.push_back(S_NUMB);    fSl.push_back(0); fL.push_back(ID_NIB);    end
            4'hA: begin mType = 3'd3; fS.push_back(S_DIST);    fSl.push_back(0); fL.push_back(DIST_NIB);  end
            4'hB: begin mType = 3'd4; fS.push_back(S_DELAY);   fSl.push_back(0); fL.push_back(DELAY_NIB); end
            default: begin mType = 3'd5; fS.push_back(S_DLYDIST); fSl.push_back(0); fL.push_back(DIST_NIB); end
        endcase
        fS.push_back(S_FRMCRC); fSl.push_back(eff > 0 ? eff - 1 : 0); fL.push_back(FRM_CRC_NIB);
        push(1'b1, soc, fS[0], mType, 4'(fSl[0]), 4'd0, 1'b0, 1'b0);
        n = 0;
        for (int k = 0; k < fS.size(); k++) begin
            for (int i = 0; i < fL[k]; i++) begin
                if (n == abortAt) begin
                    mType = 3'd0;
                    push(1'b0, 4'h0, S_IDLE, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1);
                    return;
                end
                if (fS[k] == S_SLOT && fSl[k] == my) expOwn++;
                g = 4'($urandom_range(0, 15));
                if (i < fL[k] - 1)
                    push(1'b1, g, fS[k], mType, 4'(fSl[k]), 4'(i + 1), 1'b0, 1'b0);
                else if (k == fS.size() - 1)
                    push(1'b1, g, S_IDLE, mType, 4'd0, 4'd0, 1'b1, 1'b0);
                else
                    push(1'b1, g, fS[k + 1], mType, 4'(fSl[k + 1]), 4'd0, 1'b0, 1'b0);
                n++;
            end
        end
    endtask

    task automatic play(input string name);
        step_t s;
        int idx;
        ownCnt = 0;
        idx = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge MRxClk);
            MRxDV = s.dv;
            MRxD  = s.d;
            #1 if (OwnSlot) ownCnt++;
            @(posedge MRxClk);
            #1;
            checks++;
            if ({State, FrameType, SlotIdx, NibCnt, FrameDone, FrameErr} !== {s.st, s.ty, s.sl, s.nc, s.dn, s.er}) begin
                errors++;
                $display("FAIL %s step %0d: got st=%0d ty=%0d sl=%0d nc=%0d dn=%b er=%b, want st=%0d ty=%0d sl=%0d nc=%0d dn=%b er=%b",
                         name, idx, State, FrameType, SlotIdx, NibCnt, FrameDone, FrameErr,
                         s.st, s.ty, s.sl, s.nc, s.dn, s.er);
            end
            idx++;
        end
        checks++;
        if (ownCnt !== expOwn) begin
            errors++;
            $display("FAIL %s own_slot_cycles: got %0d, want %0d", name, ownCnt, expOwn);
        end
        expOwn = 0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({State, FrameType, SlotIdx, NibCnt, FrameDone, FrameErr, OwnSlot} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got st=%0d ty=%0d sl=%0d nc=%0d dn=%b er=%b own=%b, want all 0",
                     State, FrameType, SlotIdx, NibCnt, FrameDone, FrameErr, OwnSlot);
        end
        repeat (2) @(posedge MRxClk);
        @(negedge MRxClk);
        Reset_n = 1'b1;
    endtask

    task automatic test_data_frame;
        NumSlaves = 5'd3; MySlaveId = 4'd1;
        build(0, 15, 4'hD, 3, 1, -1);
        add_idle(2);
        play("data3");
    endtask

    task automatic test_slave_bounds;
        NumSlaves = 5'd0; MySlaveId = 4'd0;
        build(0, 4, 4'hD, 0, 0, -1);
        add_idle(1);
        play("slaves0");
        NumSlaves = 5'd20; MySlaveId = 4'd15;
        build(1, 6, 4'hD, 20, 15, -1);
        add_idle(1);
        play("slaves20");
    endtask

    task automatic test_ctrl_frames;
        logic [3:0] socs [4];
        socs = '{4'h9, 4'hA, 4'hB, 4'hC};
        foreach (socs[i]) begin
            build(0, int'($urandom_range(1, 15)), socs[i], int'(NumSlaves), int'(MySlaveId), -1);
            add_idle(1);
            play("ctrl");
        end
    endtask

    task automatic test_abort;
        NumSlaves = 5'd3; MySlaveId = 4'd1;
        build(0, 7, 4'hD, 3, 1, 2 * (SLOT_NIB + CRC_NIB) + 5);
        add_idle(2);
        play("abort_slot2");
    endtask

    task automatic test_unknown_soc;
        for (int i = 0; i < 3; i++) push(1'b1, 4'h5, S_PRE, mType, 4'd0, 4'd0, 1'b0, 1'b0);
        push(1'b1, 4'h7, S_FFS, mType, 4'd0, 4'd0, 1'b0, 1'b1);
        push(1'b1, 4'h3, S_FFS, mType, 4'd0, 4'd0, 1'b0, 1'b0);
        push(1'b0, 4'h0, S_IDLE, mType, 4'd0, 4'd0, 1'b0, 1'b0);
        play("unknown_soc");
    endtask

    task automatic test_back_to_back;
        NumSlaves = 5'd2; MySlaveId = 4'd0;
        build(0, 3, 4'h9, 2, 0, -1);
        build(0, 5, 4'hD, 2, 0, -1);
        build(0, 2, 4'hB, 2, 0, -1);
        add_idle(1);
        play("back_to_back");
    endtask

    task automatic test_async_reset;
        NumSlaves = 5'd3; MySlaveId = 4'd1;
        build(0, 5, 4'hD, 3, 1, -1);
        while (q.size() > 5 + 1 + SLOT_NIB + CRC_NIB + 3) q.delete(q.size() - 1);
        expOwn = 3;
        play("pre_reset");
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({State, FrameType, SlotIdx, NibCnt, FrameDone, FrameErr, OwnSlot} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: got st=%0d ty=%0d sl=%0d nc=%0d dn=%b er=%b own=%b, want all 0",
                     State, FrameType, SlotIdx, NibCnt, FrameDone, FrameErr, OwnSlot);
        end
        @(negedge MRxClk);
        Reset_n = 1'b1;
        MRxDV = 1'b0;
        mType = 3'd0;
        build(0, 15, 4'hD, 3, 1, -1);
        add_idle(1);
        play("post_reset");
    endtask

    task automatic test_random_frames;
        logic [3:0] socs [5];
        int ns, my, ab;
        socs = '{4'hD, 4'h9, 4'hA, 4'hB, 4'hC};
        for (int f = 0; f < 25; f++) begin
            ns = int'($urandom_range(0, 20));
            my = int'($urandom_range(0, 15));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1;
            NumSlaves = 5'(ns);
            MySlaveId = 4'(my);
            build(int'($urandom_range(0, 2)), int'($urandom_range(1, 15)), socs[$urandom_range(0, 4)], ns, my, ab);
            add_idle(int'($urandom_range(0, 2)));
            play("random");
        end
    endtask

    initial begin
        test_reset;
        test_data_frame;
        test_slave_bounds;
        test_ctrl_frames;
        test_abort;
        test_unknown_soc;
        test_back_to_back;
        test_async_reset;
        test_random_frames;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
